// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ctrl
//  Purpose  : HD44780 character-LCD write engine. CPU writes arrive as
//             rising edges of a strobe bit in a 32-bit I/O word. Each one is
//             queued in a 4-entry FIFO and played out with RS/DATA setup, an
//             EN pulse, hold, and a post-write wait.
//  Ports    : clk_i       sole clock
//             rst_i       synchronous active-high reset
//             lcd_word_i  [31] display on, [10] write strobe, [9] RS, [7:0] data
//             lcd_on_o    panel power/backlight (lcd_word_i[31], one cycle late)
//             lcd_rs_o    HD44780 RS
//             lcd_rw_o    HD44780 RW (always 0, write-only)
//             lcd_en_o    HD44780 EN
//             lcd_data_o  HD44780 DB[7:0]
//             busy_o      engine active, FIFO non-empty, or init running
//             full_o      FIFO holds 4 entries
//             overflow_o  sticky: a strobe was dropped on a full FIFO
//  Options  : LCD_INIT_SEQ_EN -- when defined, a power-up delay of
//             T_POWERUP cycles is followed by the writes 0x38, 0x0C, 0x01,
//             0x06 (RS=0) before any FIFO entry is played out.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 12,
   parameter int T_HOLD    = 2,
   parameter int T_WAIT    = 2000,
   parameter int T_CLEAR   = 82000,
   parameter int T_POWERUP = 750000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lcd_word_i,
   output logic        lcd_on_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o,
   output logic        busy_o,
   output logic        full_o,
   output logic        overflow_o
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_setup = 3'd1;
   localparam logic [2:0] c_st_pulse = 3'd2;
   localparam logic [2:0] c_st_hold  = 3'd3;
   localparam logic [2:0] c_st_wait  = 3'd4;

   // Every phase loads (length - 1) and leaves when the counter reads zero,
   // so a phase of length N occupies exactly N cycles.
   localparam logic [19:0] c_setup_m1 = 20'(T_SETUP - 1);
   localparam logic [19:0] c_pulse_m1 = 20'(T_PULSE - 1);
   localparam logic [19:0] c_hold_m1  = 20'(T_HOLD - 1);
   localparam logic [19:0] c_wait_m1  = 20'(T_WAIT - 1);
   localparam logic [19:0] c_clear_m1 = 20'(T_CLEAR - 1);

   localparam logic [2:0] c_fifo_depth = 3'd4;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [19:0] r_cnt;
   logic        w_cnt_zero;

   logic        r_strobe_prev;
   logic        w_push;
   logic        w_push_ok;
   logic        w_pop;
   logic        w_start;
   logic [8:0]  w_push_entry;
   logic [8:0]  w_src;

   logic [8:0]  r_fifo [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic        w_fifo_empty;
   logic        w_fifo_full;

   logic        r_overflow;
   logic        r_on;
   logic        r_rs;
   logic [7:0]  r_data;
   logic [19:0] w_wait_m1;

   logic        w_init_busy;
   logic        w_init_issue;

   // Bits of the CPU word that this block does not interpret.
   logic        w_unused_bits;
   assign w_unused_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};

   // ------------------------------------------------------------------------
   // Strobe edge detect and FIFO control
   // ------------------------------------------------------------------------
   assign w_push       = lcd_word_i[10] & ~r_strobe_prev;
   assign w_push_entry = {lcd_word_i[9], lcd_word_i[7:0]};
   assign w_fifo_empty = (r_count == 3'd0);
   assign w_fifo_full  = (r_count == c_fifo_depth);
   assign w_cnt_zero   = (r_cnt == 20'd0);

   // A push on a full FIFO still fits when the head leaves on the same cycle.
   assign w_push_ok = w_push & (~w_fifo_full | w_pop);

   // Queue entries only drain from IDLE, and never while init owns the bus.
   assign w_pop   = (r_state == c_st_idle) & ~w_fifo_empty & ~w_init_busy;
   assign w_start = w_pop | w_init_issue;

   // Clear (0x01) and return-home (0x02) commands need the long wait.
   assign w_wait_m1 = (~r_rs && (r_data == 8'h01 || r_data == 8'h02)) ?
                      c_clear_m1 : c_wait_m1;

`ifdef LCD_INIT_SEQ_EN
   // ------------------------------------------------------------------------
   // Power-up initialisation: the shared counter first times the power-up
   // delay (loaded at reset), then four fixed commands go through the
   // normal SETUP..WAIT path.
   // ------------------------------------------------------------------------
   localparam logic [19:0] c_cnt_rst = 20'(T_POWERUP - 1);

   logic       r_pwr_wait;
   logic [2:0] r_init_idx;
   logic [7:0] w_init_cmd;

   always_comb begin
      w_init_cmd = 8'h38;
      case (r_init_idx)
         3'd0:    w_init_cmd = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
         3'd1:    w_init_cmd = 8'h0C;   // display on, cursor off
         3'd2:    w_init_cmd = 8'h01;   // clear display
         3'd3:    w_init_cmd = 8'h06;   // entry mode: increment, no shift
         default: w_init_cmd = 8'h38;
      endcase
   end

   assign w_init_busy  = r_pwr_wait | (r_init_idx != 3'd4);
   assign w_init_issue = (r_state == c_st_idle) & ~r_pwr_wait & (r_init_idx != 3'd4);
   assign w_src        = w_init_issue ? {1'b0, w_init_cmd} : r_fifo[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pwr_wait <= 1'b1;
         r_init_idx <= 3'd0;
      end else begin
         if (r_pwr_wait && w_cnt_zero) begin
            r_pwr_wait <= 1'b0;
         end
         if (w_init_issue) begin
            r_init_idx <= r_init_idx + 3'd1;
         end
      end
   end
`else
   localparam logic [19:0] c_cnt_rst = 20'd0;
   localparam int          c_unused_powerup = T_POWERUP;

   assign w_init_busy  = 1'b0;
   assign w_init_issue = 1'b0;
   assign w_src        = r_fifo[r_rd_ptr];
`endif

   // ------------------------------------------------------------------------
   // FIFO storage (contents need no reset: the pointers define validity)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_fifo[r_wr_ptr] <= w_push_entry;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
         if (w_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:  if (w_start)    w_state_next = c_st_setup;
         c_st_setup: if (w_cnt_zero) w_state_next = c_st_pulse;
         c_st_pulse: if (w_cnt_zero) w_state_next = c_st_hold;
         c_st_hold:  if (w_cnt_zero) w_state_next = c_st_wait;
         c_st_wait:  if (w_cnt_zero) w_state_next = c_st_idle;
         default:                    w_state_next = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: strobe history, latched RS/DATA, shared phase counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // Strobe history resets high so a strobe held through reset is
         // not mistaken for a fresh rising edge.
         r_strobe_prev <= 1'b1;
         r_on          <= 1'b0;
         r_rs          <= 1'b0;
         r_data        <= 8'h00;
         r_cnt         <= c_cnt_rst;
      end else begin
         r_strobe_prev <= lcd_word_i[10];
         r_on          <= lcd_word_i[31];
         if (w_start) begin
            r_rs   <= w_src[8];
            r_data <= w_src[7:0];
         end
         case (r_state)
            c_st_idle: begin
               // Outside init the counter is already zero here; with init
               // enabled this branch times the power-up delay.
               if (w_start)          r_cnt <= c_setup_m1;
               else if (!w_cnt_zero) r_cnt <= r_cnt - 20'd1;
            end
            c_st_setup: begin
               if (w_cnt_zero) r_cnt <= c_pulse_m1;
               else            r_cnt <= r_cnt - 20'd1;
            end
            c_st_pulse: begin
               if (w_cnt_zero) r_cnt <= c_hold_m1;
               else            r_cnt <= r_cnt - 20'd1;
            end
            c_st_hold: begin
               if (w_cnt_zero) r_cnt <= w_wait_m1;
               else            r_cnt <= r_cnt - 20'd1;
            end
            c_st_wait: begin
               if (!w_cnt_zero) r_cnt <= r_cnt - 20'd1;
            end
            default: r_cnt <= 20'd0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (decoded from registers only, no path from lcd_word_i)
   // ------------------------------------------------------------------------
   always_comb begin
      lcd_en_o = (r_state == c_st_pulse);
      busy_o   = (r_state != c_st_idle) | ~w_fifo_empty | w_init_busy;
   end

   assign lcd_on_o   = r_on;
   assign lcd_rs_o   = r_rs;
   assign lcd_rw_o   = 1'b0;
   assign lcd_data_o = r_data;
   assign full_o     = w_fifo_full;
   assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_ctrl
//  Purpose  : Self-checking bench for lcd_ctrl. Directed scenarios plus a
//             randomized run compared each cycle against a transaction-level
//             reference model of the queue and write timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

   localparam int TS  = 2;
   localparam int TP  = 12;
   localparam int TH  = 2;
   localparam int TW  = 40;
   localparam int TC  = 300;
   localparam int TPU = 100;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic [31:0] word = '0;
   logic        lcd_on, lcd_rs, lcd_rw, lcd_en, busy, full, ovf;
   logic [7:0]  lcd_data;

   int n_cmp = 0;
   int n_bad = 0;

   lcd_ctrl #(
      .T_SETUP   (TS),
      .T_PULSE   (TP),
      .T_HOLD    (TH),
      .T_WAIT    (TW),
      .T_CLEAR   (TC),
      .T_POWERUP (TPU)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .lcd_word_i (word),
      .lcd_on_o   (lcd_on),
      .lcd_rs_o   (lcd_rs),
      .lcd_rw_o   (lcd_rw),
      .lcd_en_o   (lcd_en),
      .lcd_data_o (lcd_data),
      .busy_o     (busy),
      .full_o     (full),
      .overflow_o (ovf)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model: a queue of pending writes plus the edge number at
   // which the engine may next start a write. A write started at edge p
   // drives EN after edges p+TS .. p+TS+TP-1 and frees the engine for a new
   // start at edge p+TS+TP+TH+wait+1.
   // ------------------------------------------------------------------------
   int          cyc = 0;
   logic        m_prev = 1'b1;
   logic [8:0]  m_q[$];
   logic        m_ovf = 1'b0, m_on = 1'b0, m_rs = 1'b0;
   logic [7:0]  m_data = 8'h00;
   int          m_pop_edge = -100000;
   int          m_free = 0;
   int          m_wait = 0;
   logic        m_en = 1'b0, m_busy = 1'b0, m_full = 1'b0;

   always @(posedge clk) begin
      logic       push;
      logic [8:0] e;
      cyc = cyc + 1;
      if (rst) begin
         m_prev     = 1'b1;
         m_q.delete();
         m_ovf      = 1'b0;
         m_on       = 1'b0;
         m_rs       = 1'b0;
         m_data     = 8'h00;
         m_pop_edge = -100000;
         m_free     = cyc + 1;
      end else begin
         push   = word[10] & ~m_prev;
         m_prev = word[10];
         m_on   = word[31];
         if (cyc >= m_free && m_q.size() > 0) begin
            e          = m_q.pop_front();
            m_rs       = e[8];
            m_data     = e[7:0];
            m_pop_edge = cyc;
            m_wait     = (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02)) ? TC : TW;
            m_free     = cyc + TS + TP + TH + m_wait + 1;
         end
         if (push) begin
            if (m_q.size() < 4) m_q.push_back({word[9], word[7:0]});
            else                m_ovf = 1'b1;
         end
      end
      m_en   = (cyc >= m_pop_edge + TS) && (cyc <= m_pop_edge + TS + TP - 1);
      m_busy = (cyc < m_free - 1) || (m_q.size() > 0);
      m_full = (m_q.size() == 4);
   end

   function automatic logic [14:0] outs();
      return {lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, full, ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      word = '0;
      rst  = 1'b1;
      tick();
      tick();
      rst  = 1'b0;
      tick();
   endtask

   // Pushes one write, then follows it until busy_o drops. Offsets are in
   // edges relative to the pop edge (the edge after which SETUP begins).
   task automatic run_one(input logic [31:0] w, output int en_off, output int en_len,
                          output int busy_off, output logic [8:0] seen,
                          output bit stable, output bit tmo);
      int p;
      word = w;
      tick();
      word = w & ~32'h0000_0400;
      tick();
      p        = cyc;
      seen     = {lcd_rs, lcd_data};
      stable   = 1'b1;
      en_off   = -1;
      en_len   = 0;
      busy_off = -1;
      tmo      = 1'b1;
      for (int i = 0; i < TC + TS + TP + TH + 50; i++) begin
         tick();
         if (lcd_en) begin
            if (en_off < 0) en_off = cyc - p;
            en_len++;
         end
         if ({lcd_rs, lcd_data} !== seen) stable = 1'b0;
         if (!busy) begin
            busy_off = cyc - p;
            tmo      = 1'b0;
            break;
         end
      end
   endtask

`ifndef LCD_INIT_SEQ_EN
   task automatic test_reset();
      word = 32'h0000_0000;
      rst  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (outs() !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), 15'h0);
         end
      end
   endtask

   task automatic test_single_write();
      int en_off, en_len, busy_off;
      logic [8:0] seen;
      bit stable, tmo;
      do_reset();
      run_one(32'h0000_0641, en_off, en_len, busy_off, seen, stable, tmo);
      n_cmp++;
      if (seen !== 9'h141) begin
         n_bad++; $display("FAIL single_rs_data: got %h expected %h", seen, 9'h141);
      end
      n_cmp++;
      if (en_off !== TS) begin
         n_bad++; $display("FAIL single_en_start: got %0d expected %0d", en_off, TS);
      end
      n_cmp++;
      if (en_len !== TP) begin
         n_bad++; $display("FAIL single_en_width: got %0d expected %0d", en_len, TP);
      end
      n_cmp++;
      if (busy_off !== TS + TP + TH + TW) begin
         n_bad++; $display("FAIL single_busy_fall: got %0d expected %0d", busy_off, TS + TP + TH + TW);
      end
      n_cmp++;
      if (!stable || tmo) begin
         n_bad++; $display("FAIL single_stable: stable %0d timeout %0d expected 1 0", stable, tmo);
      end
   endtask

   task automatic test_clear_wait();
      logic [31:0] words [5] = '{32'h0000_0401, 32'h0000_0402, 32'h0000_0403,
                                 32'h0000_0601, 32'h0000_0400};
      int          waits [5] = '{TC, TC, TW, TW, TW};
      int en_off, en_len, busy_off;
      logic [8:0] seen;
      bit stable, tmo;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         run_one(words[k], en_off, en_len, busy_off, seen, stable, tmo);
         n_cmp++;
         if (busy_off !== TS + TP + TH + waits[k] || tmo) begin
            n_bad++;
            $display("FAIL wait_len[%0d]: busy fell at %0d expected %0d", k, busy_off, TS + TP + TH + waits[k]);
         end
         n_cmp++;
         if (seen !== {words[k][9], words[k][7:0]} || en_len !== TP) begin
            n_bad++;
            $display("FAIL wait_write[%0d]: got %h/%0d expected %h/%0d", k, seen, en_len,
                     {words[k][9], words[k][7:0]}, TP);
         end
      end
   endtask

   task automatic test_fifo_overflow();
      logic [7:0] em [8];
      int  n_em = 0;
      bit  full_seen = 1'b0, ovf_lost = 1'b0, done = 1'b0, prev_en = 1'b0;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         word = (i < 12 && i % 2 == 0) ? (32'h0000_0600 | (32'h30 + 32'(i / 2))) : 32'h0;
         tick();
         if (full) full_seen = 1'b1;
         if (i == 8) begin
            n_cmp++;
            if (ovf !== 1'b0 || full !== 1'b1) begin
               n_bad++; $display("FAIL ovf_fill: ovf %b full %b expected 0 1", ovf, full);
            end
         end
         if (i == 10) begin
            n_cmp++;
            if (ovf !== 1'b1) begin
               n_bad++; $display("FAIL ovf_set: got %b expected 1", ovf);
            end
         end
         if (i > 10 && ovf !== 1'b1) ovf_lost = 1'b1;
         if (lcd_en && !prev_en) begin
            if (n_em < 8) em[n_em] = lcd_data;
            n_em++;
         end
         prev_en = lcd_en;
         if (i >= 12 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!done || !full_seen || ovf_lost) begin
         n_bad++;
         $display("FAIL ovf_flags: done %0d full_seen %0d ovf_lost %0d expected 1 1 0", done, full_seen, ovf_lost);
      end
      n_cmp++;
      if (n_em !== 5) begin
         n_bad++; $display("FAIL ovf_count: got %0d writes expected 5", n_em);
      end
      for (int k = 0; k < 5 && k < n_em; k++) begin
         n_cmp++;
         if (em[k] !== 8'h30 + 8'(k)) begin
            n_bad++; $display("FAIL ovf_data[%0d]: got %h expected %h", k, em[k], 8'h30 + 8'(k));
         end
      end
   endtask

   task automatic test_strobe_through_reset();
      int  n_en = 0;
      bit  prev_en = 1'b0, done = 1'b0;
      word = 32'h0000_0400;
      rst  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if ({busy, full, lcd_en} !== 3'b000) begin
         n_bad++; $display("FAIL held_strobe: busy/full/en %b expected 000", {busy, full, lcd_en});
      end
      word = 32'h0;
      tick();
      word = 32'h0000_0400;
      tick();
      for (int i = 0; i < 300; i++) begin
         tick();
         if (lcd_en && !prev_en) n_en++;
         prev_en = lcd_en;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      word = 32'h0;
      tick();
      n_cmp++;
      if (n_en !== 1 || !done) begin
         n_bad++; $display("FAIL toggle_one_write: got %0d writes (done %0d) expected 1", n_en, done);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int en_off, en_len, busy_off;
      logic [8:0] seen;
      bit stable, tmo, hit = 1'b0;
      do_reset();
      word = 32'h0000_0655;
      tick();
      word = 32'h0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (lcd_en) begin
            hit = 1'b1;
            break;
         end
      end
      word = 32'h0000_04AA;
      tick();
      word = 32'h0;
      rst  = 1'b1;
      tick();
      n_cmp++;
      if (!hit || outs() !== 15'h0) begin
         n_bad++; $display("FAIL midpulse_reset: got %h (pulse seen %0d) expected %h", outs(), hit, 15'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (busy !== 1'b0 || lcd_en !== 1'b0) begin
         n_bad++; $display("FAIL midpulse_fifo_empty: busy %b en %b expected 0 0", busy, lcd_en);
      end
      run_one(32'h0000_0442, en_off, en_len, busy_off, seen, stable, tmo);
      n_cmp++;
      if (seen !== 9'h042 || en_len !== TP || busy_off !== TS + TP + TH + TW || tmo) begin
         n_bad++;
         $display("FAIL midpulse_after: data %h en %0d busy %0d expected %h %0d %0d", seen, en_len,
                  busy_off, 9'h042, TP, TS + TP + TH + TW);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic [14:0] exp_v;
      int sel, rate;
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         w = $urandom();
         rate = (i < 3000) ? 15 : 2;
         w[10] = (i < 5200) && ($urandom_range(0, rate) == 0);
         sel = $urandom_range(0, 7);
         if (sel == 0) w[7:0] = 8'h01;
         if (sel == 1) w[7:0] = 8'h02;
         word = w;
         rst  = ($urandom_range(0, 1499) == 0);
         tick();
         exp_v = {m_on, m_rs, 1'b0, m_en, m_data, m_busy, m_full, m_ovf};
         n_cmp++;
         if (outs() !== exp_v) begin
            n_bad++; $display("FAIL random_cycle %0d: dut %h model %h", i, outs(), exp_v);
         end
      end
      rst  = 1'b0;
      word = 32'h0;
   endtask
`else
   task automatic test_init();
      logic [8:0] exp_seq [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h141};
      logic [8:0] got [8];
      int r, first = -1, n = 0;
      bit busy_gap = 1'b0, prev_en = 1'b0;
      word = '0;
      rst  = 1'b1;
      tick();
      r   = cyc;
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++; $display("FAIL init_busy_reset: got %b expected 1", busy);
      end
      for (int i = 0; i < 4000 && n < 5; i++) begin
         word = (i == 10) ? 32'h0000_0641 : 32'h0;
         tick();
         if (lcd_en && !prev_en) begin
            if (first < 0) first = cyc - r;
            got[n] = {lcd_rs, lcd_data};
            n++;
         end
         if (first < 0 && !busy) busy_gap = 1'b1;
         prev_en = lcd_en;
      end
      n_cmp++;
      if (n !== 5) begin
         n_bad++; $display("FAIL init_count: got %0d writes expected 5", n);
      end
      n_cmp++;
      if (first < TPU || busy_gap) begin
         n_bad++; $display("FAIL init_powerup: first EN at %0d busy gap %0d expected >=%0d 0", first, busy_gap, TPU);
      end
      for (int k = 0; k < 5 && k < n; k++) begin
         n_cmp++;
         if (got[k] !== exp_seq[k]) begin
            n_bad++; $display("FAIL init_seq[%0d]: got %h expected %h", k, got[k], exp_seq[k]);
         end
      end
   endtask
`endif

   initial begin
`ifdef LCD_INIT_SEQ_EN
      test_init();
`else
      test_reset();
      test_single_write();
      test_clear_wait();
      test_fifo_overflow();
      test_strobe_through_reset();
      test_reset_mid_pulse();
      test_random();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  T_SETUP 2: cycles RS/DATA are stable before EN rises.
  T_PULSE 12: EN high width.
  T_HOLD 2: cycles RS/DATA are held after EN falls.
  T_WAIT 2000: post-write wait for ordinary writes.
  T_CLEAR 82000: post-write wait for clear/home commands.
  T_POWERUP 750000: power-up delay, used only with LCD_INIT_SEQ_EN.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk_i  in  1  sole clock.
  rst_i  in  1  reset, synchronous, active-high.
  lcd_word_i  in  32  CPU LCD I/O word. [31] = display on, [10] = write strobe, [9] = RS, [7:0] = data.
  lcd_on_o  out  1  panel power/backlight.
  lcd_rs_o  out  1  HD44780 RS.
  lcd_rw_o  out  1  HD44780 RW, tied 0.
  lcd_en_o  out  1  HD44780 EN.
  lcd_data_o  out  8  HD44780 DB[7:0].
  busy_o  out  1  engine active or FIFO non-empty.
  full_o  out  1  FIFO full.
  overflow_o  out  1  sticky; a strobe was dropped.
REQ-003 The block SHALL use one clock, clk_i, and a synchronous active-high reset, rst_i.

Function
REQ-004 A push SHALL occur on the cycle lcd_word_i[10]=1 while the registered previous value of bit 10 is 0. The push writes {lcd_word_i[9], lcd_word_i[7:0]} into a 4-entry, 9-bit FIFO.
REQ-005 A push while full SHALL drop the entry and set overflow_o=1. overflow_o SHALL be cleared only by reset.
REQ-006 A push and a pop on the same cycle SHALL both take effect; occupancy is unchanged and full_o is unaffected. Pointers SHALL wrap modulo 4.
REQ-007 The FSM SHALL have five states: IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-008 IDLE with FIFO non-empty SHALL pop the head. On the next cycle the FSM enters SETUP, with lcd_rs_o and lcd_data_o registered from the popped entry.
REQ-009 SETUP SHALL last T_SETUP cycles, then PULSE.
REQ-010 PULSE SHALL hold lcd_en_o=1 for exactly T_PULSE cycles, then HOLD.
REQ-011 HOLD SHALL last T_HOLD cycles, then WAIT.
REQ-012 WAIT SHALL last T_CLEAR cycles if RS=0 and data is 0x01 or 0x02, otherwise T_WAIT cycles, then IDLE.
REQ-013 lcd_rs_o and lcd_data_o SHALL remain constant from SETUP entry until the next pop.
REQ-014 lcd_en_o SHALL be 1 only in PULSE.
REQ-015 A single 20-bit down-counter SHALL serve all states. A strobe arriving in any state SHALL only push, never disturb the current transfer.
REQ-016 lcd_on_o SHALL be lcd_word_i[31] registered one cycle.
REQ-017 busy_o SHALL be 1 when state≠IDLE, or FIFO non-empty, or the init sequence is running. It is registered-consistent with state, with no combinational path from lcd_word_i.
REQ-018 lcd_rw_o SHALL be constant 0.

Reset
REQ-019 On rst_i=1 at a clock edge, the block SHALL reset to:
  state = IDLE
  FIFO emptied
  counter = 0
  strobe-previous register = 1, so a strobe held high through reset does not push
  outputs: lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00, lcd_on_o=0, busy_o=0, full_o=0, overflow_o=0
REQ-020 Reset asserted mid-transfer SHALL abort it on that edge, dropping EN the next cycle. No partial state SHALL survive.

Configuration
REQ-021 Macro LCD_INIT_SEQ_EN.
  When defined: after reset, wait T_POWERUP cycles with busy_o=1. Then issue RS=0 writes 0x38, 0x0C, 0x01, 0x06 through SETUP..WAIT, per REQ-009..012. FIFO pops begin only after the sequence completes. Pushes are accepted throughout.
  When undefined: no init logic; the FSM starts in IDLE with busy_o=0 immediately after reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios (LCD_INIT_SEQ_EN undefined unless stated):
  1. Reset, then word 0x0000_0641 (strobe, RS=1, 0x41) for one cycle -> lcd_rs_o=1, lcd_data_o=0x41; EN high exactly 12 cycles, starting 2 cycles after SETUP entry; busy_o falls 2000+16 cycles after SETUP entry.
  2. Word 0x0000_0401 (RS=0, 0x01) -> WAIT lasts 82000 cycles; busy_o stays 1 throughout.
  3. Six strobes with data 0x30..0x35, each 1 cycle, spaced 2 cycles apart, during one transfer -> 0x30..0x33 or 0x34 emitted per FIFO capacity; full_o=1 observed; overflow_o=1 and stays 1; the dropped entries never appear on lcd_data_o.
  4. Strobe held at 1 across reset deassertion -> no push, busy_o=0. Then toggle the strobe 0→1 -> exactly one write.
  5. rst_i pulsed for 1 cycle during PULSE -> lcd_en_o=0 next cycle; FIFO empty; later strobe 0x42 transfers normally.
  6. LCD_INIT_SEQ_EN defined, T_POWERUP=100 -> busy_o=1 from reset; first EN at cycle ≥100; data sequence 0x38, 0x0C, 0x01, 0x06 (RS=0); a user strobe 0x41 pushed during init emits after 0x06.
